// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the sensor/debounce front end, the phase controller
// and the lamp drivers.
interface traffic_phase_controller_if #(
    parameter int NUM_PHASES = 4,
    parameter int PH_W       = $clog2(NUM_PHASES)
) ();
    logic                    tick;
    logic [NUM_PHASES-1:0]   req;
    logic                    preempt;
    logic [PH_W-1:0]         preempt_phase;
    logic [2*NUM_PHASES-1:0] lights;
    logic [PH_W-1:0]         active_phase;
    logic                    phase_start;

    modport master (
        output tick, req, preempt, preempt_phase,
        input  lights, active_phase, phase_start
    );

    modport slave (
        input  tick, req, preempt, preempt_phase,
        output lights, active_phase, phase_start
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// N-phase intersection controller: tick-timed green/yellow/all-red cycling with
// demand-driven round-robin phase selection and emergency preemption.
module traffic_phase_controller #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 40,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_controller_if.slave   bus
);
    localparam int PH_W = $clog2(NUM_PHASES);

    localparam logic [CNT_W:0]   GMIN_L   = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   GMAX_L   = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALR_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PH_W:0]    NUM_PH_L = (PH_W+1)'(NUM_PHASES);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         active_q, active_d;
    logic [PH_W-1:0]         next_q, next_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    start_q, start_d;

    logic                    pre_act_s;
    logic                    other_s;
    logic                    green_go_s;
    logic [PH_W-1:0]         cand_s;
    logic [NUM_PHASES-1:0]   req_others_s;
    logic [CNT_W:0]          cnt_p1_s;
    logic [2*NUM_PHASES-1:0] lights_s;

    // Out-of-range preempt_phase means preemption is not in effect.
    assign pre_act_s = bus.preempt & ({1'b0, bus.preempt_phase} < NUM_PH_L);
    assign cnt_p1_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Competing demand and round-robin candidate search starting after the active phase.
    always_comb begin
        logic [PH_W:0] sum_v;
        req_others_s           = bus.req;
        req_others_s[active_q] = 1'b0;
        other_s                = |req_others_s;
        cand_s                 = active_q;
        sum_v                  = '0;
        // Walk farthest to nearest so the nearest requesting phase wins.
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            sum_v = {1'b0, active_q} + (PH_W+1)'(k);
            if (sum_v >= NUM_PH_L) begin
                sum_v = sum_v - NUM_PH_L;
            end else begin
                sum_v = sum_v;
            end
            cand_s = req_others_s[sum_v[PH_W-1:0]] ? sum_v[PH_W-1:0] : cand_s;
        end
    end

    // Green termination: preemption elsewhere bypasses min green; otherwise gap-out or max-out.
    always_comb begin
        green_go_s = 1'b0;
        if (pre_act_s) begin
            green_go_s = (bus.preempt_phase != active_q);
        end else begin
            green_go_s = other_s && (cnt_p1_s >= GMIN_L) &&
                         (!bus.req[active_q] || (cnt_p1_s >= GMAX_L));
        end
    end

    // Next-state, phase latches and counter; nothing moves without a tick.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        next_d   = next_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        if (bus.tick) begin
            case (state_q)
                ST_GREEN: begin
                    if (green_go_s) begin
                        state_d = ST_YELLOW;
                        next_d  = pre_act_s ? bus.preempt_phase : cand_s;
                    end else begin
                        state_d = ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (cnt_q == YEL_LAST) begin
                        state_d = ST_ALLRED;
                    end else begin
                        state_d = ST_YELLOW;
                    end
                end
                ST_ALLRED: begin
                    if (cnt_q == ALR_LAST) begin
                        state_d  = ST_GREEN;
                        active_d = pre_act_s ? bus.preempt_phase : next_q;
                        start_d  = 1'b1;
                    end else begin
                        state_d = ST_ALLRED;
                    end
                end
                default: begin
                    state_d = ST_GREEN;
                end
            endcase
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_p1_s[CNT_W-1:0];
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, phase and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_GREEN;
            active_q <= '0;
            next_q   <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            next_q   <= next_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
        end
    end

    // Lamp decode: only the active phase can be non-red, and never in all-red.
    always_comb begin
        lights_s = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == active_q) begin
                case (state_q)
                    ST_GREEN:  lights_s[2*i +: 2] = 2'b10;
                    ST_YELLOW: lights_s[2*i +: 2] = 2'b01;
                    default:   lights_s[2*i +: 2] = 2'b00;
                endcase
            end else begin
                lights_s[2*i +: 2] = 2'b00;
            end
        end
    end

    assign bus.lights       = lights_s;
    assign bus.active_phase = active_q;
    assign bus.phase_start  = start_q;
endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-phase signalised-intersection controller. It is the next generation of the team's two-road fixed-sequence traffic FSM. It adds tick-based phase timing (minimum, maximum, yellow and all-red), demand-driven round-robin phase selection, and emergency preemption. It sits between the sensor/debounce front end (`req`, `preempt`) and the lamp drivers (`lights`). One instance controls one intersection.

## Interface
Parameters:
- `NUM_PHASES`, default 4: number of signal phases (≥2).
- `CNT_W`, default 8: width of the timing counter.
- `GREEN_MIN`, default 10: minimum green in ticks (≥1).
- `GREEN_MAX`, default 40: maximum green in ticks under competing demand (≥`GREEN_MIN`, <2^`CNT_W`).
- `YELLOW_T`, default 3: yellow duration in ticks (≥1).
- `ALLRED_T`, default 2: all-red clearance in ticks (≥1).
- `PH_W` (derived) = `$clog2(NUM_PHASES)`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: single-cycle timebase enable. All durations are counted in cycles where `tick`=1.
- `req`, in, `NUM_PHASES`: per-phase demand, level-sensitive.
- `preempt`, in, 1: emergency preemption request, level-sensitive.
- `preempt_phase`, in, `PH_W`: phase to serve during preemption (values ≥`NUM_PHASES` are ignored, and preemption is treated as inactive).
- `lights`, out, 2*`NUM_PHASES`: per-phase lamp code. Phase i uses bits [2i+1:2i], encoded RED=00, YELLOW=01, GREEN=10. The code 11 is never driven.
- `active_phase`, out, `PH_W`: the phase currently green, yellow, or last served.
- `phase_start`, out, 1: one-cycle pulse in the first cycle of every new green.

## Operation
- The state machine has three states: GREEN, YELLOW and ALLRED.
- Registers: state, `active_phase`, `next_phase`, and `cnt` (`CNT_W` bits).
- `cnt` clears on every state entry. It increments on `tick` and saturates at all-ones.
- `lights` is decoded combinationally from the state and `active_phase`:
  - In GREEN and YELLOW, the active phase shows GREEN or YELLOW respectively; all other phases show RED.
  - In ALLRED, every phase shows RED.
- `other` is true when any bit of `req` is set other than `req[active_phase]`.
- `cand` is the first phase with its `req` bit set, searching round-robin from `active_phase`+1 and wrapping from `NUM_PHASES`-1 to 0. The active phase itself is excluded.
- GREEN exits to YELLOW on a `tick` cycle when either condition holds:
  - (a) preemption is active and `preempt_phase` ≠ `active_phase`. The minimum green is ignored; the exit happens on the next tick.
  - (b) `other` is true, `cnt`+1 ≥ `GREEN_MIN`, and either `req[active_phase]`=0 (gap-out) or `cnt`+1 ≥ `GREEN_MAX` (max-out).
- With no competing demand, green holds indefinitely. `cnt` saturates and does not wrap.
- On GREEN→YELLOW, `next_phase` latches `preempt_phase` if preemption is active, otherwise `cand`.
- YELLOW exits to ALLRED on the tick where `cnt` = `YELLOW_T`-1. Preemption does not abort or shorten yellow.
- ALLRED exits to GREEN on the tick where `cnt` = `ALLRED_T`-1. On exit, `active_phase` loads `preempt_phase` if preemption is active at that edge, otherwise `next_phase`.
- A phase whose demand disappears during clearance is still served for the full `GREEN_MIN`.
- While preemption is active and the preempted phase is green, GREEN holds regardless of other demand. Normal rules resume the cycle after `preempt` deasserts.

## Timing
- Reset values (asynchronous, immediate):
  - state = GREEN, `active_phase`=0, `next_phase`=0, `cnt`=0, `phase_start`=0.
  - `lights` = phase 0 GREEN, all others RED.
- All transitions take effect at the rising edge where `tick`=1 and the exit condition holds. `lights` changes in the cycle after that edge, with no further latency.
- Durations:
  - Green lasts exactly max(`GREEN_MIN`, demand-determined) ticks.
  - Yellow lasts exactly `YELLOW_T` ticks.
  - All-red lasts exactly `ALLRED_T` ticks.
- `phase_start` is registered. It is 1 for exactly the first cycle of GREEN after ALLRED, and never after reset.
- When `tick`=0, no state, counter, or latch changes. Inputs are sampled only on tick edges.
- Reset asserted mid-operation (including during YELLOW or ALLRED) returns to phase 0 GREEN immediately, with no clearance sequence.

## Test plan
Bench configuration: `NUM_PHASES`=4, `GREEN_MIN`=3, `GREEN_MAX`=6, `YELLOW_T`=2, `ALLRED_T`=1, `tick`=1 every cycle.
- **Reset and hold:** reset, then `req`=0 for 50 cycles → `lights`=8'b00_00_00_10 constant, `active_phase`=0, `phase_start` never asserts.
- **Gap-out:** `req`=4'b0100 from cycle 0 after reset → phase 0 GREEN for 3 cycles, YELLOW for 2, all RED for 1, then phase 2 GREEN with `phase_start`=1 for one cycle.
- **Max-out and round-robin wrap:** `req`=4'b1001 held, starting with phase 3 active → phase 3 GREEN for 6 cycles, then clearance, then phase 0. Phase 0 GREEN for 6 cycles, then phase 3. Phases 1 and 2 are never served.
- **Preemption:**
  - `preempt`=1 with `preempt_phase`=1 at green `cnt`=0 on phase 0 → YELLOW on the next cycle, ignoring min green; phase 1 GREEN after 2+1 cycles.
  - Phase 1 holds with `req`=4'b1111 until `preempt` drops.
- **Preempt during clearance:** assert `preempt` with `preempt_phase`=3 during YELLOW toward phase 2 → yellow and all-red keep full length, then phase 3 GREEN instead of phase 2.
- **Reset mid-yellow, and tick gating:**
  - Reset during YELLOW → phase 0 GREEN in the same cycle.
  - `tick` at 1-in-4 cycles → all durations scale by 4 exactly.
